reg_transfer_ctrl: RTL and testbench
====================================

// Module: reg_transfer_ctrl
// PURPOSE
//  Control sequencer directly upstream of the 4-bit register file.
//  Accepts one instruction at a time over a valid/ready handshake and drives the register-transfer strobes in sequence.
//  Strobes: per-register R_in/R_out, immediate bus driver, ALU A/G load, G bus driver.
//  Guarantees exactly one bus driver per transfer cycle.
// PARAMETERS
//  NUM_REGS  4  registers controlled; one r_in/r_out bit each (2..4)
//  DATA_W    4  bus/immediate width
// PORTS
//  clk          in   1         rising-edge clock
//  reset        in   1         asynchronous, active-low; clears all state
//  instr_valid  in   1         instruction offered
//  instr_ready  out  1         high only in IDLE; accept = valid & ready
//  opcode       in   3         000 MOV, 001 MVI, 010 ADD, 011 SUB, 100 XOR (opt), else reserved
//  rx           in   2         destination register index
//  ry           in   2         source register index
//  imm          in   DATA_W    immediate for MVI
//  r_in         out  NUM_REGS  one-hot register load enables
//  r_out        out  NUM_REGS  one-hot register bus-drive enables
//  imm_out_en   out  1         drive imm_val onto bus
//  imm_val      out  DATA_W    latched immediate
//  a_in         out  1         load ALU A register from bus
//  g_in         out  1         load ALU G = A op bus
//  g_out        out  1         drive G onto bus
//  alu_op       out  2         00 add, 01 sub, 10 xor; held with g_in
//  done         out  1         1-cycle pulse in final step
//  illegal      out  1         1-cycle pulse for reserved opcode or rx/ry >= NUM_REGS
// BEHAVIOUR
//  Reset (async, reset==0):
//  - State goes to IDLE.
//  - All strobes, done, illegal, alu_op and imm_val are 0; instr_ready=1.
//  - Reset mid-instruction aborts it: no further strobes, and done does not fire.
//  Latching:
//  - On accept, opcode/rx/ry/imm are latched.
//  - Inputs are ignored while busy.
//  FSM states: IDLE -> T1 -> T2 -> T3 -> IDLE.
//  - Outputs are decoded from state and latched fields.
//  - Outputs are registered-state Moore; no input-to-output combinational path except instr_ready.
//  MOV (1 step):
//  - T1: r_out[ry], r_in[rx], done -> IDLE.
//  MVI (1 step):
//  - T1: imm_out_en, r_in[rx], done -> IDLE.
//  ADD/SUB/XOR (3 steps):
//  - T1: r_out[rx], a_in.
//  - T2: r_out[ry], g_in, alu_op.
//  - T3: g_out, r_in[rx], done -> IDLE.
//  Illegal (reserved opcode or rx/ry out of range):
//  - T1: illegal and done pulse together, no strobes -> IDLE.
//  Latency and throughput:
//  - Accept at edge k; first strobe in cycle k+1.
//  - Next accept is possible in the done cycle+1; no back-to-back overlap.
//  Boundary conditions:
//  - rx==ry is legal: MOV is a self-copy; ADD gives Rx=2*Rx.
//  - instr_valid held high across done: the next instruction is accepted in the IDLE cycle after done.
//  Invariant, every cycle:
//  - popcount({r_out, imm_out_en, g_out}) <= 1.
//  - popcount(r_in) <= 1.
// CONFIGURATION
//  RTC_XOR_OP_EN defined:
//  - opcode 100 = XOR, sequenced like ADD with alu_op=10.
//  RTC_XOR_OP_EN undefined:
//  - opcode 100 is reserved and takes the illegal path.
//  - alu_op never takes value 10.
// STRUCTURE
//  Package rtc_pkg holds:
//  - opcode localparams (OP_MOV, OP_MVI, OP_ADD, OP_SUB, OP_XOR).
//  - state encoding (S_IDLE, S_T1, S_T2, S_T3).
//  - alu_op codes.
//  Sub-module rtc_onehot_dec: index -> NUM_REGS one-hot with enable.
//  - Instanced twice, once for r_in and once for r_out.
// TESTING
//  1. Reset low mid-ADD in T2 -> all strobes 0 immediately, instr_ready=1, no done.
//  2. MOV rx=2, ry=1 -> next cycle r_out=0010, r_in=0100, done=1; then idle.
//  3. MVI rx=3, imm=4'hA -> imm_out_en=1, imm_val=A, r_in=1000, done=1.
//  4. ADD rx=0, ry=3 -> T1 r_out=0001+a_in; T2 r_out=1000+g_in, alu_op=00; T3 g_out+r_in=0001+done.
//  5. opcode 100 -> with RTC_XOR_OP_EN: 3 steps, alu_op=10; without it: illegal=done=1 in T1, no strobes.
//  6. instr_valid held high with SUB then MOV -> SUB accepted, ready low 3 cycles, MOV accepted the cycle after done.
//  - The bus-driver invariant is checked by assertion in all scenarios.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared definitions for the register-transfer control sequencer:
// opcode values, FSM state encoding, ALU operation codes and small decode helpers.
// Optional feature macro: RTC_XOR_OP_EN (opcode 100 becomes XOR instead of reserved).
package rtc_pkg;

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

  // True for every opcode this build implements; anything else goes down the illegal path.
  function automatic logic rtc_op_legal(input logic [2:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_MOV, OP_MVI, OP_ADD, OP_SUB: ok = 1'b1;
`ifdef RTC_XOR_OP_EN
      OP_XOR:                         ok = 1'b1;
`endif
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Opcodes that need the three-step A/G sequence.
  function automatic logic rtc_is_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR);
  endfunction

  // ALU operation presented alongside g_in; unknown opcodes fall back to add.
  function automatic logic [1:0] rtc_alu_code(input logic [2:0] op);
    logic [1:0] code;
    code = ALU_ADD;
    case (op)
      OP_SUB:  code = ALU_SUB;
`ifdef RTC_XOR_OP_EN
      OP_XOR:  code = ALU_XOR;
`endif
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rtc_onehot_dec.sv
// Register index to one-hot enable vector, gated by a single enable bit.
// Used once for the register load strobes and once for the bus-drive strobes.
module rtc_onehot_dec #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N-1:0]     onehot
);

  // One comparator per register; at most one bit can match a given index.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign onehot[gi] = en && (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/reg_transfer_ctrl.sv
// Control sequencer for the 4-bit register file: accepts one instruction at a
// time over valid/ready and steps through the register-transfer strobes.
// All strobes come from flops; only instr_ready is decoded from state directly.
// Optional feature macro: RTC_XOR_OP_EN (enables opcode 100 as XOR).
module reg_transfer_ctrl
  import rtc_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [2:0]          opcode,
  input  logic [1:0]          rx,
  input  logic [1:0]          ry,
  input  logic [DATA_W-1:0]   imm,
  output logic [NUM_REGS-1:0] r_in,
  output logic [NUM_REGS-1:0] r_out,
  output logic                imm_out_en,
  output logic [DATA_W-1:0]   imm_val,
  output logic                a_in,
  output logic                g_in,
  output logic                g_out,
  output logic [1:0]          alu_op,
  output logic                done,
  output logic                illegal
);

  state_t            state_reg;
  logic [2:0]        op_reg;
  logic [1:0]        rx_reg;
  logic [1:0]        ry_reg;
  logic [DATA_W-1:0] imm_reg;
  logic              ill_reg;

  logic              r_in_en_reg;
  logic [1:0]        r_in_idx_reg;
  logic              r_out_en_reg;
  logic [1:0]        r_out_idx_reg;
  logic              imm_out_en_reg;
  logic              a_in_reg;
  logic              g_in_reg;
  logic              g_out_reg;
  logic [1:0]        alu_op_reg;
  logic              done_reg;
  logic              illegal_reg;

  logic accept;
  logic instr_bad;

  // Handshake: ready only while idle, so nothing is accepted mid-sequence.
  assign instr_ready = (state_reg == S_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign instr_bad   = !rtc_op_legal(opcode) ||
                       (32'(rx) >= NUM_REGS) || (32'(ry) >= NUM_REGS);

  // Sequencer: state, latched fields and the strobes for the step being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      op_reg         <= '0;
      rx_reg         <= '0;
      ry_reg         <= '0;
      imm_reg        <= '0;
      ill_reg        <= 1'b0;
      r_in_en_reg    <= 1'b0;
      r_in_idx_reg   <= '0;
      r_out_en_reg   <= 1'b0;
      r_out_idx_reg  <= '0;
      imm_out_en_reg <= 1'b0;
      a_in_reg       <= 1'b0;
      g_in_reg       <= 1'b0;
      g_out_reg      <= 1'b0;
      alu_op_reg     <= ALU_ADD;
      done_reg       <= 1'b0;
      illegal_reg    <= 1'b0;
    end else begin
      // Every strobe is a single-cycle pulse unless the next step sets it again.
      r_in_en_reg    <= 1'b0;
      r_out_en_reg   <= 1'b0;
      imm_out_en_reg <= 1'b0;
      a_in_reg       <= 1'b0;
      g_in_reg       <= 1'b0;
      g_out_reg      <= 1'b0;
      alu_op_reg     <= ALU_ADD;
      done_reg       <= 1'b0;
      illegal_reg    <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            op_reg    <= opcode;
            rx_reg    <= rx;
            ry_reg    <= ry;
            imm_reg   <= imm;
            ill_reg   <= instr_bad;
            state_reg <= S_T1;
            if (instr_bad) begin
              done_reg    <= 1'b1;
              illegal_reg <= 1'b1;
            end else begin
              case (opcode)
                OP_MOV: begin
                  r_out_en_reg  <= 1'b1;
                  r_out_idx_reg <= ry;
                  r_in_en_reg   <= 1'b1;
                  r_in_idx_reg  <= rx;
                  done_reg      <= 1'b1;
                end
                OP_MVI: begin
                  imm_out_en_reg <= 1'b1;
                  r_in_en_reg    <= 1'b1;
                  r_in_idx_reg   <= rx;
                  done_reg       <= 1'b1;
                end
                default: begin
                  // ALU ops: first copy Rx into A.
                  r_out_en_reg  <= 1'b1;
                  r_out_idx_reg <= rx;
                  a_in_reg      <= 1'b1;
                end
              endcase
            end
          end
        end
        S_T1: begin
          if (ill_reg || !rtc_is_alu(op_reg)) begin
            state_reg <= S_IDLE;
          end else begin
            // G = A op Ry.
            r_out_en_reg  <= 1'b1;
            r_out_idx_reg <= ry_reg;
            g_in_reg      <= 1'b1;
            alu_op_reg    <= rtc_alu_code(op_reg);
            state_reg     <= S_T2;
          end
        end
        S_T2: begin
          // Write G back into Rx.
          g_out_reg    <= 1'b1;
          r_in_en_reg  <= 1'b1;
          r_in_idx_reg <= rx_reg;
          done_reg     <= 1'b1;
          state_reg    <= S_T3;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  rtc_onehot_dec #(.N(NUM_REGS), .IDX_W(2)) u_r_in_dec (
    .idx    (r_in_idx_reg),
    .en     (r_in_en_reg),
    .onehot (r_in)
  );

  rtc_onehot_dec #(.N(NUM_REGS), .IDX_W(2)) u_r_out_dec (
    .idx    (r_out_idx_reg),
    .en     (r_out_en_reg),
    .onehot (r_out)
  );

  assign imm_out_en = imm_out_en_reg;
  assign imm_val    = imm_reg;
  assign a_in       = a_in_reg;
  assign g_in       = g_in_reg;
  assign g_out      = g_out_reg;
  assign alu_op     = alu_op_reg;
  assign done       = done_reg;
  assign illegal    = illegal_reg;

endmodule

// File: tb/tb_reg_transfer_ctrl.sv
// Self-checking bench for reg_transfer_ctrl: table of instructions whose expected
// per-cycle output snapshots go through a scoreboard queue, plus hand-written
// sequences for reset mid-instruction and valid held high across done.
module tb_reg_transfer_ctrl;

  logic       clk;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] opcode;
  logic [1:0] rx;
  logic [1:0] ry;
  logic [3:0] imm;
  logic [3:0] r_in;
  logic [3:0] r_out;
  logic       imm_out_en;
  logic [3:0] imm_val;
  logic       a_in;
  logic       g_in;
  logic       g_out;
  logic [1:0] alu_op;
  logic       done;
  logic       illegal;

  reg_transfer_ctrl #(.NUM_REGS(4), .DATA_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .rx          (rx),
    .ry          (ry),
    .imm         (imm),
    .r_in        (r_in),
    .r_out       (r_out),
    .imm_out_en  (imm_out_en),
    .imm_val     (imm_val),
    .a_in        (a_in),
    .g_in        (g_in),
    .g_out       (g_out),
    .alu_op      (alu_op),
    .done        (done),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ready;
    logic [3:0] r_in;
    logic [3:0] r_out;
    logic       imm_out_en;
    logic [3:0] imm_val;
    logic       a_in;
    logic       g_in;
    logic       g_out;
    logic [1:0] alu_op;
    logic       done;
    logic       illegal;
  } snap_t;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [1:0] rx;
    logic [1:0] ry;
    logic [3:0] imm;
    logic       exp_ill;
    int         exp_steps;
    logic [1:0] exp_alu;
  } vec_t;

  localparam int NV = 11;
  vec_t  tbl [NV];
  snap_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  function automatic vec_t mk(string name, logic [2:0] op, logic [1:0] vx, logic [1:0] vy,
                              logic [3:0] vimm, logic ill, int steps, logic [1:0] alu);
    vec_t v;
    v.name = name; v.op = op; v.rx = vx; v.ry = vy; v.imm = vimm;
    v.exp_ill = ill; v.exp_steps = steps; v.exp_alu = alu;
    return v;
  endfunction

  function automatic snap_t sample();
    snap_t s;
    s.ready = instr_ready; s.r_in = r_in; s.r_out = r_out; s.imm_out_en = imm_out_en;
    s.imm_val = imm_val; s.a_in = a_in; s.g_in = g_in; s.g_out = g_out;
    s.alu_op = alu_op; s.done = done; s.illegal = illegal;
    return s;
  endfunction

  function automatic snap_t idle_snap(logic [3:0] iv);
    snap_t s;
    s = '0;
    s.ready = 1'b1;
    s.imm_val = iv;
    return s;
  endfunction

  // Expected snapshots for each step of an instruction, followed by the idle cycle after it.
  task automatic push_exp(input vec_t v);
    snap_t      s;
    logic [3:0] ohx;
    logic [3:0] ohy;
    ohx = 4'b0001 << v.rx;
    ohy = 4'b0001 << v.ry;
    s = '0; s.imm_val = v.imm;
    if (v.exp_ill) begin
      s.done = 1'b1; s.illegal = 1'b1;
      exp_q.push_back(s);
    end else if (v.exp_steps == 1) begin
      if (v.op == 3'b001) s.imm_out_en = 1'b1;
      else                s.r_out = ohy;
      s.r_in = ohx; s.done = 1'b1;
      exp_q.push_back(s);
    end else begin
      s.r_out = ohx; s.a_in = 1'b1;
      exp_q.push_back(s);
      s = '0; s.imm_val = v.imm;
      s.r_out = ohy; s.g_in = 1'b1; s.alu_op = v.exp_alu;
      exp_q.push_back(s);
      s = '0; s.imm_val = v.imm;
      s.g_out = 1'b1; s.r_in = ohx; s.done = 1'b1;
      exp_q.push_back(s);
    end
    exp_q.push_back(idle_snap(v.imm));
  endtask

  task automatic check(input string name, input snap_t exp);
    snap_t act;
    act = sample();
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (fields rdy,r_in,r_out,imm_en,imm,a,g_in,g_out,alu,done,ill)",
               name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic drive(input vec_t v, input logic vld);
    opcode = v.op; rx = v.rx; ry = v.ry; imm = v.imm; instr_valid = vld;
  endtask

  // Called at a negedge in an idle cycle; returns at the negedge of the idle cycle after done.
  task automatic run_vec(input vec_t v);
    snap_t e;
    drive(v, 1'b1);
    push_exp(v);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    opcode = 3'($urandom); rx = 2'($urandom); ry = 2'($urandom); imm = 4'($urandom);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check(v.name, e);
    end
  endtask

  // Bus-driver and load-enable invariants, every cycle.
  always @(negedge clk) begin
    assert ($countones({r_out, imm_out_en, g_out}) <= 1)
    else begin
      miscompares++;
      $display("FAIL bus_driver_invariant: drivers=%b%b%b allowed at most one", r_out, imm_out_en, g_out);
    end
    assert ($countones(r_in) <= 1)
    else begin
      miscompares++;
      $display("FAIL r_in_invariant: r_in=%b allowed at most one", r_in);
    end
  end

  initial begin
    snap_t e;
    vec_t  sub_v;
    vec_t  mov_v;
    vec_t  add_v;

    reset = 1'b0; instr_valid = 1'b0; opcode = '0; rx = '0; ry = '0; imm = '0;

    tbl[0]  = mk("mov_r2_r1",     3'b000, 2'd2, 2'd1, 4'h0, 1'b0, 1, 2'b00);
    tbl[1]  = mk("mvi_r3_A",      3'b001, 2'd3, 2'd0, 4'hA, 1'b0, 1, 2'b00);
    tbl[2]  = mk("add_r0_r3",     3'b010, 2'd0, 2'd3, 4'h1, 1'b0, 3, 2'b00);
    tbl[3]  = mk("sub_r1_r2",     3'b011, 2'd1, 2'd2, 4'h2, 1'b0, 3, 2'b01);
    tbl[4]  = mk("mov_self_r1",   3'b000, 2'd1, 2'd1, 4'h3, 1'b0, 1, 2'b00);
    tbl[5]  = mk("add_self_r2",   3'b010, 2'd2, 2'd2, 4'h4, 1'b0, 3, 2'b00);
`ifdef RTC_XOR_OP_EN
    tbl[6]  = mk("xor_r3_r0",     3'b100, 2'd3, 2'd0, 4'h5, 1'b0, 3, 2'b10);
`else
    tbl[6]  = mk("op100_illegal", 3'b100, 2'd3, 2'd0, 4'h5, 1'b1, 1, 2'b00);
`endif
    tbl[7]  = mk("op101_illegal", 3'b101, 2'd1, 2'd2, 4'h6, 1'b1, 1, 2'b00);
    tbl[8]  = mk("op111_illegal", 3'b111, 2'd0, 2'd0, 4'h7, 1'b1, 1, 2'b00);
    tbl[9]  = mk("mvi_r0_F",      3'b001, 2'd0, 2'd3, 4'hF, 1'b0, 1, 2'b00);
    tbl[10] = mk("sub_r3_r0",     3'b011, 2'd3, 2'd0, 4'h8, 1'b0, 3, 2'b01);

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_state", idle_snap(4'h0));
    reset = 1'b1;
    @(negedge clk);
    check("idle_after_reset", idle_snap(4'h0));

    for (int i = 0; i < NV; i++) run_vec(tbl[i]);

    // Reset asserted during T2 of an ADD: strobes drop at once, no done afterwards.
    add_v = mk("add_reset_mid", 3'b010, 2'd1, 2'd2, 4'h5, 1'b0, 3, 2'b00);
    drive(add_v, 1'b1);
    push_exp(add_v);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk); e = exp_q.pop_front(); check("add_reset_T1", e);
    @(negedge clk); e = exp_q.pop_front(); check("add_reset_T2", e);
    exp_q.delete();
    #1 reset = 1'b0;
    #1 check("async_reset_mid_add", idle_snap(4'h0));
    @(negedge clk); check("held_in_reset", idle_snap(4'h0));
    reset = 1'b1;
    @(negedge clk); check("no_done_after_abort", idle_snap(4'h0));
    @(negedge clk); check("still_idle", idle_snap(4'h0));

    // instr_valid held high: SUB, then MOV accepted in the idle cycle after done.
    sub_v = mk("sub_held", 3'b011, 2'd2, 2'd0, 4'h3, 1'b0, 3, 2'b01);
    mov_v = mk("mov_held", 3'b000, 2'd3, 2'd1, 4'h9, 1'b0, 1, 2'b00);
    drive(sub_v, 1'b1);
    push_exp(sub_v);
    @(posedge clk); #1;
    drive(mov_v, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); e = exp_q.pop_front(); check("sub_held_step", e);
    end
    @(negedge clk); e = exp_q.pop_front(); check("held_idle_gap", e);
    push_exp(mov_v);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    while (exp_q.size() > 0) begin
      @(negedge clk); e = exp_q.pop_front(); check("mov_after_held", e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
